// File: rtl/clockworks_div.sv
// Board-clock divider and reset stretcher: clk = CLK / 2^SLOW, resetn held low for 2+RESET_HOLD
// CLK edges after RESETN release, tick marks the first CLK cycle of every clk high phase.
module clockworks_div #(
   parameter int SLOW       = 21,
   parameter int RESET_HOLD = 16
) (
   input  logic CLK,
   input  logic RESETN,
   output logic clk,
   output logic resetn,
   output logic tick
);

   localparam logic [7:0] HOLD = 8'(RESET_HOLD);

   logic       sync1;
   logic       sync2;
   logic [7:0] hold_cnt;
   logic       rst_q;

   // Two-flop synchronizer followed by a saturating stretch counter; rst_q is sticky until RESETN drops.
   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         sync1    <= 1'b0;
         sync2    <= 1'b0;
         hold_cnt <= 8'd0;
         rst_q    <= 1'b0;
      end else begin
         sync1 <= 1'b1;
         sync2 <= sync1;
         if (sync2 && !rst_q && hold_cnt != HOLD)
            hold_cnt <= hold_cnt + 8'd1;
         if (HOLD == 8'd0)
            rst_q <= rst_q | sync1;
         else
            rst_q <= rst_q | (sync2 && hold_cnt == HOLD - 8'd1);
      end
   end

   assign resetn = rst_q;

   generate
      if (SLOW == 0) begin : g_nodiv
         assign clk  = CLK;
         assign tick = rst_q;
      end else begin : g_div
         localparam logic [SLOW-1:0] HALF = SLOW'(1) << (SLOW - 1);

         logic [SLOW-1:0] div_cnt;
         logic [SLOW-1:0] div_nxt;
         logic            tick_q;

         assign div_nxt = div_cnt + SLOW'(1);

         // tick is registered against the next count so it lines up with the clk rise itself.
         always_ff @(posedge CLK or negedge RESETN) begin
            if (!RESETN) begin
               div_cnt <= '0;
               tick_q  <= 1'b0;
            end else if (!rst_q) begin
               div_cnt <= '0;
               tick_q  <= 1'b0;
            end else begin
               div_cnt <= div_nxt;
               tick_q  <= (div_nxt == HALF);
            end
         end

         assign clk  = div_cnt[SLOW-1];
         assign tick = tick_q;
      end
   endgenerate

endmodule

// File: tb/tb_clockworks_div.sv
// Randomized reset/run stimulus on four divider configurations, checked against an
// edge-count model plus literal per-edge tables and a long-run edge census.
module tb_clockworks_div;

   logic CLK;
   logic RESETN;
   logic a_clk, a_rst, a_tick;
   logic b_clk, b_rst, b_tick;
   logic c_clk, c_rst, c_tick;
   logic d_clk, d_rst, d_tick;

   int     checks = 0;
   int     errors = 0;
   bit     cmp_en = 0;
   longint n      = 0;

   clockworks_div #(.SLOW(3),  .RESET_HOLD(4))  u_a (.CLK(CLK), .RESETN(RESETN), .clk(a_clk), .resetn(a_rst), .tick(a_tick));
   clockworks_div #(.SLOW(3),  .RESET_HOLD(0))  u_b (.CLK(CLK), .RESETN(RESETN), .clk(b_clk), .resetn(b_rst), .tick(b_tick));
   clockworks_div #(.SLOW(0),  .RESET_HOLD(2))  u_c (.CLK(CLK), .RESETN(RESETN), .clk(c_clk), .resetn(c_rst), .tick(c_tick));
   clockworks_div #(.SLOW(12), .RESET_HOLD(16)) u_d (.CLK(CLK), .RESETN(RESETN), .clk(d_clk), .resetn(d_rst), .tick(d_tick));

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // n = CLK rising edges that have seen RESETN high since it last went low.
   always @(posedge CLK or negedge RESETN) begin
      if (!RESETN) n <= 0;
      else         n <= n + 1;
   end

   // Expected {clk, tick, resetn} purely from the edge count.
   function automatic logic [2:0] model(longint cnt, int s, int h, logic clk_lvl);
      longint c;
      longint per;
      longint half;
      if (cnt < 2 + h) return {(s == 0) ? clk_lvl : 1'b0, 2'b00};
      if (s == 0) return {clk_lvl, 2'b11};
      per  = 64'sd1 <<< s;
      half = 64'sd1 <<< (s - 1);
      c    = (cnt - 2 - h) % per;
      return {(c >= half), (c == half), 1'b1};
   endfunction

   task automatic check3(string name, logic [2:0] act, logic [2:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got {clk,tick,resetn}=%b want %b", name, $time, act, exp);
      end
   endtask

   task automatic check_int(string name, longint act, longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   always @(posedge CLK or negedge CLK) begin
      #1;
      if (cmp_en) begin
         check3("model_a", {a_clk, a_tick, a_rst}, model(n, 3, 4, CLK));
         check3("model_b", {b_clk, b_tick, b_rst}, model(n, 3, 0, CLK));
         check3("model_c", {c_clk, c_tick, c_rst}, model(n, 0, 2, CLK));
         check3("model_d", {d_clk, d_tick, d_rst}, model(n, 12, 16, CLK));
      end
   end

   task automatic set_reset(logic v);
      @(negedge CLK);
      #2 RESETN = v;
   endtask

   // Per-edge literal expectations for the two SLOW=3 instances after a release.
   task automatic literal_seq(string tag);
      logic [2:0] exp_a [1:14];
      logic [2:0] exp_b [1:14];
      exp_a = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b001, 3'b001,
                3'b001, 3'b001, 3'b111, 3'b101, 3'b101, 3'b101, 3'b001};
      exp_b = '{3'b000, 3'b001, 3'b001, 3'b001, 3'b001, 3'b111, 3'b101,
                3'b101, 3'b101, 3'b001, 3'b001, 3'b001, 3'b001, 3'b111};
      for (int k = 1; k <= 14; k++) begin
         @(posedge CLK);
         #2;
         check3({tag, "_a_edge"}, {a_clk, a_tick, a_rst}, exp_a[k]);
         check3({tag, "_b_edge"}, {b_clk, b_tick, b_rst}, exp_b[k]);
      end
   endtask

   task automatic glitch_check(string tag);
      @(negedge CLK);
      #2 RESETN = 1'b0;
      #1;
      check3({tag, "_a"}, {a_clk, a_tick, a_rst}, 3'b000);
      check3({tag, "_d"}, {d_clk, d_tick, d_rst}, 3'b000);
      check3({tag, "_c"}, {c_tick, c_rst}, 2'b00);
      #1 RESETN = 1'b1;
   endtask

   initial begin
      int rises, ticks, highs, guard;
      logic prev;
      RESETN = 1'b0;
      #1 cmp_en = 1;
      repeat (5) @(posedge CLK);
      #2;
      check3("reset_a", {a_clk, a_tick, a_rst}, 3'b000);
      check3("reset_d", {d_clk, d_tick, d_rst}, 3'b000);

      set_reset(1'b1);
      literal_seq("first");

      // Glitch while u_a clk is high, then the full sequence must repeat from zero.
      guard = 0;
      while (!(a_clk === 1'b1) && guard < 20) begin
         @(negedge CLK);
         guard++;
      end
      check_int("wait_a_clk_high", (guard < 20) ? 1 : 0, 1);
      glitch_check("glitch");
      literal_seq("after_glitch");

      // Randomized reset pulses, run lengths and glitches.
      for (int e = 0; e < 20; e++) begin
         if ($urandom_range(0, 2) == 0) begin
            glitch_check("rand_glitch");
         end else begin
            set_reset(1'b0);
            repeat ($urandom_range(0, 4)) @(posedge CLK);
            set_reset(1'b1);
         end
         repeat ($urandom_range(10, 150)) @(posedge CLK);
      end

      // Long run on the SLOW=12 instance: 2^13 edges after resetn gives two clk periods.
      set_reset(1'b0);
      repeat (3) @(posedge CLK);
      set_reset(1'b1);
      guard = 0;
      while (d_rst !== 1'b1 && guard < 40) begin
         @(posedge CLK);
         #2;
         guard++;
      end
      check_int("d_resetn_edge", guard, 18);
      rises = 0; ticks = 0; highs = 0; prev = d_clk;
      for (int k = 0; k < 8192; k++) begin
         @(posedge CLK);
         #2;
         if (d_clk && !prev) rises++;
         if (d_tick) ticks++;
         if (d_clk) highs++;
         prev = d_clk;
      end
      check_int("d_clk_rises", rises, 2);
      check_int("d_ticks", ticks, 2);
      check_int("d_high_cycles", highs, 4096);

      cmp_en = 0;
      #20;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/clockworks_div.md
Name: clockworks_div

Overview:
- Clock-and-reset generator between the board oscillator pin and the CPU core.
- Divides the board clock CLK by 2^SLOW to produce a slow core clock, clk, so that state-machine activity is visible on an LED.
- Also produces a synchronized, stretched active-low reset, resetn, and a one-CLK-cycle tick marking each rising edge of clk.
- The CPU top level instantiates it with SLOW=21.

Parameters:
- SLOW, 21, log2 of the division ratio; 0 means no division (clk = CLK).
- RESET_HOLD, 16, extra CLK cycles resetn stays low after RESETN release and synchronization; legal range 0..255.

Ports:
- CLK  input  1  board clock; every register in the block is clocked on CLK rising edge.
- RESETN  input  1  asynchronous, active-low reset.
- clk  output  1  divided clock; period 2^SLOW CLK cycles, 50% duty.
- resetn  output  1  active-low reset for downstream logic; asserts asynchronously, deasserts synchronously to CLK.
- tick  output  1  one-CLK-cycle pulse coincident with the first CLK cycle of each clk high phase.

Behaviour:
- Reset asserted (RESETN=0), immediately and asynchronously:
  - divider counter = 0, clk = 0, tick = 0, resetn = 0;
  - 2-flop synchronizer cleared;
  - stretch counter = 0.
- Reset release:
  - RESETN passes through a 2-flop synchronizer;
  - the stretch counter then counts RESET_HOLD CLK cycles;
  - resetn rises on the (2+RESET_HOLD)-th CLK rising edge after RESETN rises (setup met), and is registered (glitch-free).
- Divider counter: SLOW bits wide, held at 0 while resetn=0, increments by 1 on each CLK edge while resetn=1, wraps from 2^SLOW-1 to 0.
- clk output:
  - SLOW>=1: clk = counter[SLOW-1], driven directly from the flop; 2^(SLOW-1) CLK cycles low, then 2^(SLOW-1) high.
  - The first clk rise occurs 2^(SLOW-1) CLK cycles after resetn rises.
- tick output:
  - Registered; high exactly for the CLK cycle in which counter == 2^(SLOW-1), i.e. the first CLK cycle of each clk high phase; low otherwise.
  - Low while resetn=0.
- SLOW=0 case:
  - clk = CLK gated by nothing; counter logic absent.
  - tick = resetn (constant 1 out of reset).
- Reset asserted mid-count: all outputs return to reset values within the same CLK cycle (asynchronous). A new release repeats the full 2+RESET_HOLD sequence; no partial-count state is retained.
- RESETN glitch shorter than one CLK cycle still forces a full reset sequence.
- No other inputs; no runtime programmability.
- Outputs are never X after the first reset assertion.

Test Plan:
- SLOW=3, RESET_HOLD=4:
  - Hold RESETN=0 for 5 CLK cycles, then release -> clk=0, tick=0, resetn=0 throughout reset; resetn rises on the 6th CLK edge after release.
  - After resetn=1 -> clk low for 4 CLK cycles, high 4, low 4 (period 8); tick high only in the first CLK cycle of each high phase; 3 full periods checked.
  - Pulse RESETN low for half a CLK cycle while clk=1 -> clk, tick, resetn drop immediately; after release, the full 6-cycle reset sequence and the 4-low/4-high pattern repeat from counter=0.
- SLOW=3, RESET_HOLD=0: release reset -> resetn rises on the 2nd CLK edge; first clk rise 4 CLK cycles later.
- SLOW=0 -> clk follows CLK exactly; tick=1 whenever resetn=1.
- SLOW=21 default, run 2^22 CLK cycles after reset -> exactly 2 clk rising edges; exactly 2 tick pulses; duty 2^20 high / 2^20 low.
